// File: rtl/flex_xy_scan.sv
// flex_xy_scan: 2-D raster coordinate generator (x fastest) with a valid/ready
// handshake toward the per-pixel engine. Supports single-frame and continuous
// modes, a sticky stop request and an immediate abort.
module flex_xy_scan #(
   parameter int NUM_X_BITS = 10,
   parameter int NUM_Y_BITS = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  abort,
   input  logic                  continuous,
   input  logic [NUM_X_BITS-1:0] x_max,
   input  logic [NUM_Y_BITS-1:0] y_max,
   input  logic                  ready,
   output logic                  valid,
   output logic [NUM_X_BITS-1:0] x_out,
   output logic [NUM_Y_BITS-1:0] y_out,
   output logic                  line_end,
   output logic                  frame_end,
   output logic                  frame_done,
   output logic                  busy
);

   // DRAIN is the single post-frame cycle that carries frame_done while still busy.
   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_e;

   state_e                  state_q, state_d;
   logic [NUM_X_BITS-1:0]   x_q, x_d, xmax_q, xmax_d;
   logic [NUM_Y_BITS-1:0]   y_q, y_d, ymax_q, ymax_d;
   logic                    cont_q, cont_d;
   logic                    stop_q, stop_d;
   logic                    frame_done_q, frame_done_d;
   logic                    xfer;

   // Outputs decoded from registered state; line/frame markers only while valid.
   always_comb begin
      valid      = (state_q == SCAN);
      busy       = (state_q != IDLE);
      line_end   = valid && (x_q == xmax_q);
      frame_end  = line_end && (y_q == ymax_q);
      x_out      = x_q;
      y_out      = y_q;
      frame_done = frame_done_q;
   end

   // Next-state: raster stepping, frame wrap, stop/continuous handling; abort overrides all.
   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      xmax_d       = xmax_q;
      ymax_d       = ymax_q;
      cont_d       = cont_q;
      stop_d       = stop_q;
      frame_done_d = 1'b0;
      xfer         = (state_q == SCAN) && ready;
      case (state_q)
         IDLE: begin
            if (start) begin
               xmax_d  = x_max;
               ymax_d  = y_max;
               cont_d  = continuous;
               x_d     = '0;
               y_d     = '0;
               stop_d  = 1'b0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            // A stop arriving on the last-pixel cycle still ends this frame.
            if (cont_q && stop) stop_d = 1'b1;
            if (xfer) begin
               if (!line_end) begin
                  x_d = x_q + NUM_X_BITS'(1);
               end else if (!frame_end) begin
                  x_d = '0;
                  y_d = y_q + NUM_Y_BITS'(1);
               end else begin
                  x_d          = '0;
                  y_d          = '0;
                  frame_done_d = 1'b1;
                  if (!cont_q || stop_d) state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            state_d = IDLE;
            stop_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      if (abort) begin
         state_d      = IDLE;
         x_d          = '0;
         y_d          = '0;
         stop_d       = 1'b0;
         frame_done_d = 1'b0;
      end
   end

   // State register with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         x_q          <= '0;
         y_q          <= '0;
         xmax_q       <= '0;
         ymax_q       <= '0;
         cont_q       <= 1'b0;
         stop_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         xmax_q       <= xmax_d;
         ymax_q       <= ymax_d;
         cont_q       <= cont_d;
         stop_q       <= stop_d;
         frame_done_q <= frame_done_d;
      end
   end

endmodule
